int_fp_mac: RTL and testbench

//   Configurable multiply-accumulate engine. Each accepted (in_a, in_b) pair is multiplied and
//   the product is added to an internal accumulator, either as signed INT16 or as IEEE-754

---
 rtl/int_fp_mac_if.sv | 22 ++
 rtl/int_fp_mac.sv | 230 +++++++++++++++++++++++
 tb/tb_int_fp_mac.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/int_fp_mac_if.sv
// Operand, configuration and result signals between a stream source/sink and int_fp_mac.
interface int_fp_mac_if;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_valid_a;
  logic        in_valid_b;
  logic        config_en;
  logic        float_int;
  logic [15:0] data_num;
  logic        out_valid;
  logic [15:0] mac_out;

  modport master (
    output in_a, in_b, in_valid_a, in_valid_b, config_en, float_int, data_num,
    input  out_valid, mac_out
  );

  modport slave (
    input  in_a, in_b, in_valid_a, in_valid_b, config_en, float_int, data_num,
    output out_valid, mac_out
  );
endinterface

// File: rtl/int_fp_mac.sv
// Multiply-accumulate engine, INT16 (40-bit accumulator, saturated output) or FP16
// (RNE, flush-to-zero). Pipeline: product at accept edge, accumulate one edge later,
// result register one edge after that. rst_n is an active-high asynchronous reset.
module int_fp_mac (
  input  logic        clk,
  input  logic        rst_n,
  int_fp_mac_if.slave bus
);

  localparam logic [15:0] FP_QNAN = 16'h7E00;
  localparam logic [14:0] FP_INF  = 15'h7C00;

  // FP16 multiply, round-to-nearest-even, subnormals in and out flushed to signed zero.
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic              sr, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              g, st, up;
    logic [21:0]       p;
    logic [9:0]        m;
    logic [10:0]       mr;
    logic signed [7:0] e;
    logic [15:0]       res;
    sr     = a[15] ^ b[15];
    a_nan  = (&a[14:10]) & (|a[9:0]);
    b_nan  = (&b[14:10]) & (|b[9:0]);
    a_inf  = (&a[14:10]) & ~(|a[9:0]);
    b_inf  = (&b[14:10]) & ~(|b[9:0]);
    a_zero = ~(|a[14:10]);
    b_zero = ~(|b[14:10]);
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
    if (p[21]) begin
      m  = p[20:11];
      g  = p[10];
      st = |p[9:0];
      e  = e + 8'sd1;
    end else begin
      m  = p[19:10];
      g  = p[9];
      st = |p[8:0];
    end
    up = g & (st | m[0]);
    mr = {1'b0, m} + {10'd0, up};
    if (mr[10]) e = e + 8'sd1;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) res = FP_QNAN;
    else if (a_inf | b_inf)                                   res = {sr, FP_INF};
    else if (a_zero | b_zero)                                 res = {sr, 15'd0};
    else if (e >= 8'sd31)                                     res = {sr, FP_INF};
    else if (e <= 8'sd0)                                      res = {sr, 15'd0};
    else                                                      res = {sr, e[4:0], mr[9:0]};
    return res;
  endfunction

  // FP16 add with guard/round/sticky alignment, RNE, flush-to-zero on underflow.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, stk, up;
    logic [15:0]       big, sml, res;
    logic [13:0]       mb, ms, x;
    logic [14:0]       sum;
    logic [4:0]        d;
    logic [10:0]       mr;
    logic signed [7:0] e;
    a_nan  = (&a[14:10]) & (|a[9:0]);
    b_nan  = (&b[14:10]) & (|b[9:0]);
    a_inf  = (&a[14:10]) & ~(|a[9:0]);
    b_inf  = (&b[14:10]) & ~(|b[9:0]);
    a_zero = ~(|a[14:10]);
    b_zero = ~(|b[14:10]);
    big = (a[14:0] >= b[14:0]) ? a : b;
    sml = (a[14:0] >= b[14:0]) ? b : a;
    mb  = {1'b1, big[9:0], 3'b000};
    ms  = {1'b1, sml[9:0], 3'b000};
    d   = big[14:10] - sml[14:10];
    stk = 1'b0;
    if (d >= 5'd14) begin
      ms = 14'd1;
    end else begin
      stk = |(ms & ((14'd1 << d) - 14'd1));
      ms  = (ms >> d) | {13'd0, stk};
    end
    e   = $signed({3'b000, big[14:10]});
    sum = 15'd0;
    if (big[15] == sml[15]) begin
      sum = {1'b0, mb} + {1'b0, ms};
      if (sum[14]) begin
        x = sum[14:1] | {13'd0, sum[0]};
        e = e + 8'sd1;
      end else begin
        x = sum[13:0];
      end
    end else begin
      x = mb - ms;
      for (int i = 0; i < 13; i++) begin
        if ((x != 14'd0) && !x[13]) begin
          x = x << 1;
          e = e - 8'sd1;
        end
      end
    end
    up = x[2] & ((|x[1:0]) | x[3]);
    mr = {1'b0, x[12:3]} + {10'd0, up};
    if (mr[10]) e = e + 8'sd1;
    if (a_nan | b_nan | (a_inf & b_inf & (a[15] ^ b[15]))) res = FP_QNAN;
    else if (a_inf)                                          res = {a[15], FP_INF};
    else if (b_inf)                                          res = {b[15], FP_INF};
    else if (a_zero & b_zero)                                res = {a[15] & b[15], 15'd0};
    else if (a_zero)                                         res = b;
    else if (b_zero)                                         res = a;
    else if (x == 14'd0)                                     res = 16'h0000;
    else if (e >= 8'sd31)                                    res = {big[15], FP_INF};
    else if (e <= 8'sd0)                                     res = {big[15], 15'd0};
    else                                                     res = {big[15], e[4:0], mr[9:0]};
    return res;
  endfunction

  function automatic logic [15:0] sat16(input logic [39:0] v);
    logic [15:0] res;
    if ($signed(v) > 40'sd32767)       res = 16'h7FFF;
    else if ($signed(v) < -40'sd32768) res = 16'h8000;
    else                               res = v[15:0];
    return res;
  endfunction

  logic        cfg_mode_q, cfg_mode_d;
  logic [15:0] cfg_num_q, cfg_num_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_clr_q, pend_clr_d;
  logic        p_vld_q, p_vld_d;
  logic        p_last_q, p_last_d;
  logic        p_first_q, p_first_d;
  logic        p_mode_q, p_mode_d;
  logic [31:0] prod_q, prod_d;
  logic [39:0] acc_q, acc_d;
  logic        acc_mode_q, acc_mode_d;
  logic        o_pend_q, o_pend_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] mac_out_q, mac_out_d;

  logic        cfg_load, cfg_chg, accept;
  logic [31:0] a_sx, b_sx;

  // Accept stage: config load, pair counting, product formation.
  always_comb begin
    cfg_load   = bus.config_en && (cnt_q == 16'd0);
    cfg_mode_d = cfg_load ? bus.float_int : cfg_mode_q;
    cfg_num_d  = cfg_load ? bus.data_num : cfg_num_q;
    cfg_chg    = cfg_load && ((bus.float_int != cfg_mode_q) || (bus.data_num != cfg_num_q));
    accept     = bus.in_valid_a && bus.in_valid_b;
    a_sx       = {{16{bus.in_a[15]}}, bus.in_a};
    b_sx       = {{16{bus.in_b[15]}}, bus.in_b};
    prod_d     = cfg_mode_d ? {16'd0, fp_mul(bus.in_a, bus.in_b)} : (a_sx * b_sx);
    p_mode_d   = cfg_mode_d;
    p_vld_d    = accept;
    cnt_d      = cnt_q;
    p_last_d   = 1'b0;
    // First pair of a batch, or first pair after a config change, overwrites the accumulator.
    p_first_d  = cfg_chg || pend_clr_q || ((cfg_num_d != 16'd0) && (cnt_q == 16'd0));
    if (accept) begin
      if (cfg_num_d == 16'd0) begin
        p_last_d = 1'b1;
      end else if (cnt_q == cfg_num_d - 16'd1) begin
        cnt_d    = 16'd0;
        p_last_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    // A clear that lands with no pair must still take effect on the next product.
    if (accept)       pend_clr_d = 1'b0;
    else if (cfg_chg) pend_clr_d = 1'b1;
    else              pend_clr_d = pend_clr_q;
  end

  // Accumulate stage and output formatting.
  always_comb begin
    acc_d      = acc_q;
    acc_mode_d = acc_mode_q;
    if (p_vld_q) begin
      acc_mode_d = p_mode_q;
      if (p_mode_q)
        acc_d = {24'd0, p_first_q ? prod_q[15:0] : fp_add(acc_q[15:0], prod_q[15:0])};
      else
        acc_d = (p_first_q ? 40'd0 : acc_q) + {{8{prod_q[31]}}, prod_q};
    end else if (cfg_chg) begin
      acc_d = 40'd0;
    end
    o_pend_d    = p_vld_q && p_last_q;
    out_valid_d = o_pend_q;
    mac_out_d   = mac_out_q;
    if (o_pend_q) mac_out_d = acc_mode_q ? acc_q[15:0] : sat16(acc_q);
  end

  // Pipeline and configuration registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cfg_mode_q  <= 1'b0;
      cfg_num_q   <= 16'd0;
      cnt_q       <= 16'd0;
      pend_clr_q  <= 1'b0;
      p_vld_q     <= 1'b0;
      p_last_q    <= 1'b0;
      p_first_q   <= 1'b0;
      p_mode_q    <= 1'b0;
      prod_q      <= 32'd0;
      acc_q       <= 40'd0;
      acc_mode_q  <= 1'b0;
      o_pend_q    <= 1'b0;
      out_valid_q <= 1'b0;
      mac_out_q   <= 16'd0;
    end else begin
      cfg_mode_q  <= cfg_mode_d;
      cfg_num_q   <= cfg_num_d;
      cnt_q       <= cnt_d;
      pend_clr_q  <= pend_clr_d;
      p_vld_q     <= p_vld_d;
      p_last_q    <= p_last_d;
      p_first_q   <= p_first_d;
      p_mode_q    <= p_mode_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      acc_mode_q  <= acc_mode_d;
      o_pend_q    <= o_pend_d;
      out_valid_q <= out_valid_d;
      mac_out_q   <= mac_out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.mac_out   = mac_out_q;

endmodule

// File: tb/tb_int_fp_mac.sv
// Directed bench for int_fp_mac: hand-computed INT16 and FP16 results, latency and strobe checks.
module tb_int_fp_mac;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  int_fp_mac_if bus ();

  int_fp_mac dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_cfg(input logic m, input logic [15:0] n);
    bus.config_en = 1'b1;
    bus.float_int = m;
    bus.data_num  = n;
    tick();
    bus.config_en = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_valid_a = 1'b1;
    bus.in_valid_b = 1'b1;
    tick();
    bus.in_valid_a = 1'b0;
    bus.in_valid_b = 1'b0;
  endtask

  // Called right after the final pair's edge: strobe must appear exactly two edges later.
  task automatic expect_out(input string tag, input logic [15:0] exp);
    chk({tag, "_lat0"}, {15'd0, bus.out_valid}, 16'd0);
    tick();
    chk({tag, "_lat1"}, {15'd0, bus.out_valid}, 16'd0);
    tick();
    chk({tag, "_vld"}, {15'd0, bus.out_valid}, 16'd1);
    chk({tag, "_val"}, bus.mac_out, exp);
  endtask

  logic [15:0] run_exp [4];
  logic [15:0] fa [7];
  logic [15:0] fb [7];
  logic [15:0] fe [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b1;
    bus.in_a       = 16'd0;
    bus.in_b       = 16'd0;
    bus.in_valid_a = 1'b0;
    bus.in_valid_b = 1'b0;
    bus.config_en  = 1'b0;
    bus.float_int  = 1'b0;
    bus.data_num   = 16'd0;
    tick();
    tick();
    chk("reset_vld", {15'd0, bus.out_valid}, 16'd0);
    chk("reset_mac", bus.mac_out, 16'h0000);
    rst_n = 1'b0;
    tick();

    // INT batch of 3: 6 - 20 + 7 = -7
    load_cfg(1'b0, 16'd3);
    send_pair(16'd2, 16'd3);
    chk("int3_p1", {15'd0, bus.out_valid}, 16'd0);
    send_pair(16'hFFFC, 16'd5);
    chk("int3_p2", {15'd0, bus.out_valid}, 16'd0);
    send_pair(16'd7, 16'd1);
    expect_out("int3", 16'hFFF9);
    tick();
    chk("int3_strobe_1cyc", {15'd0, bus.out_valid}, 16'd0);
    chk("int3_hold", bus.mac_out, 16'hFFF9);

    // INT positive saturation
    load_cfg(1'b0, 16'd2);
    send_pair(16'h7FFF, 16'h7FFF);
    send_pair(16'h7FFF, 16'h7FFF);
    expect_out("int_satp", 16'h7FFF);

    // INT single-pair batches: negative saturation and an in-range negative
    load_cfg(1'b0, 16'd1);
    send_pair(16'h8000, 16'h7FFF);
    expect_out("int_satn", 16'h8000);
    send_pair(16'hFFFF, 16'h0005);
    expect_out("int_neg5", 16'hFFFB);

    // FP16 batch of 2 with config loaded on the same edge as the first pair: 2.0 + 2.0
    bus.config_en = 1'b1;
    bus.float_int = 1'b1;
    bus.data_num  = 16'd2;
    send_pair(16'h3C00, 16'h4000);
    bus.config_en = 1'b0;
    send_pair(16'h3800, 16'h4400);
    expect_out("fp_2p2", 16'h4400);

    // FP16 add ties: 2048+1 stays 2048, 2050+1 rounds to 2052
    send_pair(16'h6800, 16'h3C00);
    send_pair(16'h3C00, 16'h3C00);
    expect_out("fp_tie_even", 16'h6800);
    send_pair(16'h6801, 16'h3C00);
    send_pair(16'h3C00, 16'h3C00);
    expect_out("fp_tie_up", 16'h6802);

    // FP16 single-pair products: rounding, specials, overflow, sign
    fa = '{16'h3E00, 16'h3E00, 16'h7BFF, 16'h7C00, 16'h7C01, 16'h7C00, 16'hC000};
    fb = '{16'h3C01, 16'h3C03, 16'h4000, 16'h0000, 16'h3C00, 16'h4000, 16'h3C00};
    fe = '{16'h3E02, 16'h3E04, 16'h7C00, 16'h7E00, 16'h7E00, 16'h7C00, 16'hC000};
    load_cfg(1'b1, 16'd1);
    for (int i = 0; i < 7; i++) begin
      send_pair(fa[i], fb[i]);
      expect_out($sformatf("fp_mul%0d", i), fe[i]);
    end

    // FP16 running mode: a result for every accepted pair
    run_exp = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    load_cfg(1'b1, 16'd0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) send_pair(16'h3C00, 16'h3C00);
      else       tick();
      if (i < 2) begin
        chk($sformatf("run_vld%0d", i), {15'd0, bus.out_valid}, 16'd0);
      end else begin
        chk($sformatf("run_vld%0d", i), {15'd0, bus.out_valid}, 16'd1);
        chk($sformatf("run_val%0d", i), bus.mac_out, run_exp[i-2]);
      end
    end
    tick();
    chk("run_end_vld", {15'd0, bus.out_valid}, 16'd0);

    // Lone in_valid_a must not be accepted; full pairs then count normally: 12 + 30
    load_cfg(1'b0, 16'd2);
    bus.in_a       = 16'd100;
    bus.in_b       = 16'd100;
    bus.in_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("lone_a%0d", i), {15'd0, bus.out_valid}, 16'd0);
    end
    bus.in_valid_a = 1'b0;
    tick();
    chk("lone_a_tail", {15'd0, bus.out_valid}, 16'd0);
    send_pair(16'd3, 16'd4);
    send_pair(16'd5, 16'd6);
    expect_out("after_lone", 16'h002A);

    // Config request mid-batch is ignored: 4 + 9 + 1 in INT
    load_cfg(1'b0, 16'd3);
    send_pair(16'd2, 16'd2);
    bus.config_en = 1'b1;
    bus.float_int = 1'b1;
    bus.data_num  = 16'd1;
    send_pair(16'd3, 16'd3);
    bus.config_en = 1'b0;
    chk("cfg_ignored_vld", {15'd0, bus.out_valid}, 16'd0);
    send_pair(16'd1, 16'd1);
    expect_out("cfg_ignored", 16'h000E);

    // Reset mid-batch, then a fresh batch: 2 + 12 + 30
    send_pair(16'd10, 16'd10);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_vld", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_mid_mac", bus.mac_out, 16'h0000);
    tick();
    tick();
    chk("rst_hold_vld", {15'd0, bus.out_valid}, 16'd0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("post_rst_vld", {15'd0, bus.out_valid}, 16'd0);
    load_cfg(1'b0, 16'd3);
    send_pair(16'd1, 16'd2);
    send_pair(16'd3, 16'd4);
    send_pair(16'd5, 16'd6);
    expect_out("post_rst", 16'h002C);
    tick();
    tick();
    tick();
    chk("final_hold_vld", {15'd0, bus.out_valid}, 16'd0);
    chk("final_hold_mac", bus.mac_out, 16'h002C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
